stall_ctrl: RTL and testbench

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl.sv | 105 ++++++++++
 tb/tb_stall_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - pipeline hazard scoreboard: stall, forwarding select and MDU busy tracking
module stall_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [2:0] id_tuse_rs,
    input  logic [2:0] id_tuse_rt,
    input  logic [4:0] id_waddr,
    input  logic [2:0] id_tnew,
    input  logic       id_md_start,
    input  logic       id_md_div,
    input  logic       id_hilo_use,
    output logic       stall,
    output logic [1:0] fwd_rs_sel,
    output logic [1:0] fwd_rt_sel,
    output logic       md_busy
);

    localparam logic [2:0] TUSE_NONE = 3'd7;
    localparam logic [3:0] MULT_LAT  = 4'd5;
    localparam logic [3:0] DIV_LAT   = 4'd10;

    // Scoreboard entries for instructions already past ID
    logic [4:0] ex_waddr, mem_waddr, wb_waddr;
    logic [2:0] ex_tnew, mem_tnew, wb_tnew;
    // EX holds an md_start that issued on the last edge
    logic       ex_md;
    logic [3:0] md_cnt;

    logic rs_hazard, rt_hazard, md_hazard;

    function automatic logic [2:0] dec_sat(input logic [2:0] t);
        return (t == 3'd0) ? 3'd0 : t - 3'd1;
    endfunction

    // An operand needed before a producer's result exists cannot be forwarded yet
    function automatic logic hazard(input logic [4:0] waddr, input logic [2:0] tnew,
                                    input logic [4:0] src, input logic [2:0] tuse);
        return (waddr != 5'd0) && (waddr == src) && (tuse != TUSE_NONE) && (tuse < tnew);
    endfunction

    // Youngest ready producer wins so the most recent value of the register is used
    function automatic logic [1:0] fwd_pick(input logic [4:0] src,
                                            input logic [4:0] ea, input logic [2:0] et,
                                            input logic [4:0] ma, input logic [2:0] mt,
                                            input logic [4:0] wa, input logic [2:0] wt);
        logic [1:0] sel;
        sel = 2'd0;
        if (src != 5'd0) begin
            if (ea == src && et == 3'd0)      sel = 2'd1;
            else if (ma == src && mt == 3'd0) sel = 2'd2;
            else if (wa == src && wt == 3'd0) sel = 2'd3;
        end
        return sel;
    endfunction

    // Combinational hazard detection and forwarding selection
    always_comb begin
        rs_hazard = hazard(ex_waddr, ex_tnew, id_rs, id_tuse_rs)
                  | hazard(mem_waddr, mem_tnew, id_rs, id_tuse_rs)
                  | hazard(wb_waddr, wb_tnew, id_rs, id_tuse_rs);
        rt_hazard = hazard(ex_waddr, ex_tnew, id_rt, id_tuse_rt)
                  | hazard(mem_waddr, mem_tnew, id_rt, id_tuse_rt)
                  | hazard(wb_waddr, wb_tnew, id_rt, id_tuse_rt);
        md_busy    = (md_cnt != 4'd0);
        md_hazard  = id_hilo_use && (md_busy || ex_md);
        stall      = rs_hazard | rt_hazard | md_hazard;
        fwd_rs_sel = fwd_pick(id_rs, ex_waddr, ex_tnew, mem_waddr, mem_tnew, wb_waddr, wb_tnew);
        fwd_rt_sel = fwd_pick(id_rt, ex_waddr, ex_tnew, mem_waddr, mem_tnew, wb_waddr, wb_tnew);
    end

    // Advance the scoreboard one stage per cycle; a stall injects a bubble into EX
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_waddr  <= 5'd0;
            ex_tnew   <= 3'd0;
            mem_waddr <= 5'd0;
            mem_tnew  <= 3'd0;
            wb_waddr  <= 5'd0;
            wb_tnew   <= 3'd0;
            ex_md     <= 1'b0;
        end else begin
            mem_waddr <= ex_waddr;
            mem_tnew  <= dec_sat(ex_tnew);
            wb_waddr  <= mem_waddr;
            wb_tnew   <= dec_sat(mem_tnew);
            ex_waddr  <= stall ? 5'd0 : id_waddr;
            ex_tnew   <= stall ? 3'd0 : id_tnew;
            ex_md     <= id_md_start && !stall;
        end
    end

    // MDU latency counter: a fresh issue reloads, otherwise count down to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt <= 4'd0;
        end else if (id_md_start && !stall) begin
            md_cnt <= id_md_div ? DIV_LAT : MULT_LAT;
        end else if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// tb/tb_stall_ctrl.sv - directed scoreboard bench for stall_ctrl
module tb_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, id_waddr = '0;
    logic [2:0] id_tuse_rs = 3'd7, id_tuse_rt = 3'd7, id_tnew = '0;
    logic       id_md_start = 1'b0, id_md_div = 1'b0, id_hilo_use = 1'b0;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    stall_ctrl dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt),
        .id_waddr(id_waddr), .id_tnew(id_tnew),
        .id_md_start(id_md_start), .id_md_div(id_md_div), .id_hilo_use(id_hilo_use),
        .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       stall;
        logic [1:0] rs;
        logic [1:0] rt;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   failed = 0;
    logic started = 1'b0;

    logic [4:0] nx_rs, nx_rt, nx_waddr;
    logic [2:0] nx_tuse_rs, nx_tuse_rt, nx_tnew;
    logic       nx_ms, nx_md, nx_hu;

    task automatic id(input logic [4:0] rs, input logic [2:0] trs,
                      input logic [4:0] rt, input logic [2:0] trt,
                      input logic [4:0] wa, input logic [2:0] tn,
                      input logic ms, input logic md, input logic hu);
        nx_rs = rs; nx_tuse_rs = trs; nx_rt = rt; nx_tuse_rt = trt;
        nx_waddr = wa; nx_tnew = tn; nx_ms = ms; nx_md = md; nx_hu = hu;
    endtask

    task automatic cyc(input string tag, input logic rst, input logic es,
                       input logic [1:0] ers, input logic [1:0] ert, input logic eb);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        id_rs = nx_rs; id_tuse_rs = nx_tuse_rs; id_rt = nx_rt; id_tuse_rt = nx_tuse_rt;
        id_waddr = nx_waddr; id_tnew = nx_tnew;
        id_md_start = nx_ms; id_md_div = nx_md; id_hilo_use = nx_hu;
        exp_q.push_back('{tag: tag, stall: es, rs: ers, rt: ert, busy: eb});
        @(negedge clk);
        e = exp_q.pop_front();
        tests++;
        assert (stall === e.stall) else begin
            failed++; $error("FAIL %s stall got=%b exp=%b", e.tag, stall, e.stall);
        end
        tests++;
        assert (fwd_rs_sel === e.rs) else begin
            failed++; $error("FAIL %s fwd_rs_sel got=%0d exp=%0d", e.tag, fwd_rs_sel, e.rs);
        end
        tests++;
        assert (fwd_rt_sel === e.rt) else begin
            failed++; $error("FAIL %s fwd_rt_sel got=%0d exp=%0d", e.tag, fwd_rt_sel, e.rt);
        end
        tests++;
        assert (md_busy === e.busy) else begin
            failed++; $error("FAIL %s md_busy got=%b exp=%b", e.tag, md_busy, e.busy);
        end
    endtask

    // A new md_start must never issue while the MDU is still counting
    always @(negedge clk) begin
        if (started && !reset) begin
            assert (!(id_md_start && !stall && md_busy)) else begin
                failed++; $error("FAIL md_issue_while_busy got=1 exp=0");
            end
        end
    end

    initial begin
        // reset state
        id(0, 7, 0, 7, 0, 0, 0, 0, 0);
        cyc("reset0", 1, 0, 0, 0, 0);
        cyc("reset1", 1, 0, 0, 0, 0);
        cyc("post_reset", 0, 0, 0, 0, 0);
        started = 1'b1;

        // lw $8 (tnew 2) then beq on $8 at tuse 0: two stalls, then WB forward
        id(0, 7, 0, 7, 8, 2, 0, 0, 0);
        cyc("lw_issue", 0, 0, 0, 0, 0);
        id(8, 0, 0, 7, 0, 0, 0, 0, 0);
        cyc("beq_stall1", 0, 1, 0, 0, 0);
        cyc("beq_stall2", 0, 1, 0, 0, 0);
        cyc("beq_fwd_wb", 0, 0, 3, 0, 0);

        // addu $9 (tnew 1) then reader of $9 on rt at tuse 1: no stall, MEM forward next cycle
        id(0, 7, 0, 7, 9, 1, 0, 0, 0);
        cyc("addu_issue", 0, 0, 0, 0, 0);
        id(0, 7, 9, 1, 0, 0, 0, 0, 0);
        cyc("rt_not_ready", 0, 0, 0, 0, 0);
        cyc("rt_fwd_mem", 0, 0, 0, 2, 0);

        // $5 written by both EX and MEM: youngest (EX) wins
        id(0, 7, 0, 7, 5, 0, 0, 0, 0);
        cyc("w5_a", 0, 0, 0, 0, 0);
        cyc("w5_b", 0, 0, 0, 0, 0);
        id(5, 1, 5, 7, 0, 0, 0, 0, 0);
        cyc("fwd_youngest", 0, 0, 1, 1, 0);

        // write to $0 never causes a hazard or forward
        id(0, 7, 0, 7, 0, 2, 0, 0, 0);
        cyc("w0_issue", 0, 0, 0, 0, 0);
        id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("r0_read", 0, 0, 0, 0, 0);

        // div then mfhi: 10 stall cycles
        id(0, 7, 0, 7, 0, 0, 1, 1, 1);
        cyc("div_issue", 0, 0, 0, 0, 0);
        id(0, 7, 0, 7, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cyc($sformatf("div_mfhi_stall%0d", i), 0, 1, 0, 0, 1);
        cyc("div_mfhi_release", 0, 0, 0, 0, 0);

        // mult then mfhi: 5 stall cycles
        id(0, 7, 0, 7, 0, 0, 1, 0, 1);
        cyc("mult_issue", 0, 0, 0, 0, 0);
        id(0, 7, 0, 7, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc($sformatf("mult_mfhi_stall%0d", i), 0, 1, 0, 0, 1);
        cyc("mult_mfhi_release", 0, 0, 0, 0, 0);

        // div, then a mult held by the busy MDU; reset lands at count 6
        id(0, 7, 0, 7, 0, 0, 1, 1, 1);
        cyc("div2_issue", 0, 0, 0, 0, 0);
        id(0, 7, 0, 7, 0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) cyc($sformatf("md_start_held%0d", i), 0, 1, 0, 0, 1);
        cyc("reset_at_6", 1, 1, 0, 0, 1);
        cyc("after_reset", 0, 0, 0, 0, 0);
        id(0, 7, 0, 7, 0, 0, 0, 0, 0);
        cyc("mult_after_reset", 0, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
